// File: rtl/up_dn_pkg.sv
// Shared constants for the generic up/down counter: count modes, direction
// encodings and the arbitrated request type passed to the next-state block.
package up_dn_pkg;

  localparam int MODE_SAT  = 0;
  localparam int MODE_WRAP = 1;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // One request per cycle after Load > Down > Up arbitration
  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_LOAD = 2'd1,
    REQ_DN   = 2'd2,
    REQ_UP   = 2'd3
  } req_e;

endpackage

// File: rtl/up_dn_next_calc.sv
// Combinational next-count calculation: bounded step up/down, clamped load,
// and the clip/wrap event, for an already-arbitrated request.
module up_dn_next_calc
  import up_dn_pkg::*;
#(
  parameter int WIDTH     = 5,
  parameter int WRAP_MODE = MODE_SAT
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] load_val,
  input  req_e             req,
  output logic [WIDTH-1:0] cnt_next,
  output logic             evt,
  output logic             apply
);

  localparam bit IS_WRAP = (WRAP_MODE == MODE_WRAP);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           cfg_ok;

  // One extra bit so overflow / underflow are visible without wrapping
  assign sum    = {1'b0, cnt} + {1'b0, step};
  assign diff   = {1'b0, cnt} - {1'b0, step};
  assign cfg_ok = (lo <= hi);

  always_comb begin
    cnt_next = cnt;
    evt      = 1'b0;
    apply    = 1'b0;
    case (req)
      REQ_LOAD: begin
        apply = 1'b1;
        if (!cfg_ok) begin
          cnt_next = load_val;
        end else if (load_val < lo) begin
          cnt_next = lo;
          evt      = 1'b1;
        end else if (load_val > hi) begin
          cnt_next = hi;
          evt      = 1'b1;
        end else begin
          cnt_next = load_val;
        end
      end
      REQ_UP: begin
        if (cfg_ok) begin
          apply = 1'b1;
          if (sum <= {1'b0, hi}) begin
            cnt_next = sum[WIDTH-1:0];
          end else begin
            cnt_next = IS_WRAP ? lo : hi;
            evt      = 1'b1;
          end
        end
      end
      REQ_DN: begin
        if (cfg_ok) begin
          apply = 1'b1;
          if ($signed(diff) >= $signed({1'b0, lo})) begin
            cnt_next = diff[WIDTH-1:0];
          end else begin
            cnt_next = IS_WRAP ? hi : lo;
            evt      = 1'b1;
          end
        end
      end
      default: begin
        cnt_next = cnt;
      end
    endcase
  end

endmodule

// File: rtl/up_dn_counter_gen.sv
// Bounded up/down counter with programmable step and limits; saturates or
// wraps at the limits and reports clip/wrap events and last count direction.
module up_dn_counter_gen
  import up_dn_pkg::*;
#(
  parameter int WIDTH     = 5,
  parameter int WRAP_MODE = MODE_SAT,
  parameter int RST_VAL   = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             Up,
  input  logic             Down,
  input  logic             Load,
  input  logic [WIDTH-1:0] IN,
  input  logic [WIDTH-1:0] STEP,
  input  logic [WIDTH-1:0] MIN,
  input  logic [WIDTH-1:0] MAX,
  output logic [WIDTH-1:0] Counter,
  output logic             High,
  output logic             Low,
  output logic             Event,
  output logic             Dir
);

  localparam logic [WIDTH-1:0] RST_CNT = RST_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] cnt_reg;
  logic             event_reg;
  logic             dir_reg;

  req_e             req;
  logic [WIDTH-1:0] cnt_next;
  logic             evt_next;
  logic             apply;

  // EN gates counting only; Load always gets through
  always_comb begin
    req = REQ_NONE;
    if (Load) begin
      req = REQ_LOAD;
    end else if (EN && Down) begin
      req = REQ_DN;
    end else if (EN && Up) begin
      req = REQ_UP;
    end
  end

  up_dn_next_calc #(
    .WIDTH     (WIDTH),
    .WRAP_MODE (WRAP_MODE)
  ) u_next_calc (
    .cnt      (cnt_reg),
    .step     (STEP),
    .lo       (MIN),
    .hi       (MAX),
    .load_val (IN),
    .req      (req),
    .cnt_next (cnt_next),
    .evt      (evt_next),
    .apply    (apply)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_reg   <= RST_CNT;
      event_reg <= 1'b0;
      dir_reg   <= DIR_UP;
    end else begin
      event_reg <= evt_next;
      if (apply) begin
        cnt_reg <= cnt_next;
      end
      if (apply && (req == REQ_UP)) begin
        dir_reg <= DIR_UP;
      end else if (apply && (req == REQ_DN)) begin
        dir_reg <= DIR_DN;
      end
    end
  end

  assign Counter = cnt_reg;
  assign Event   = event_reg;
  assign Dir     = dir_reg;
  assign High    = (cnt_reg == MAX);
  assign Low     = (cnt_reg == MIN);

endmodule
